ex_mem_req_unit: RTL
====================

Name: ex_mem_req_unit

Overview:
- Parametrised data-memory request unit for the EX stage. It replaces the fixed 32-bit, single-cycle SRAM strobe/wdata path with a request/response bus that uses req/addr_ok/data_ok handshakes.
- It generates byte strobes, replicated write data and the misaligned-access exception (ADEM).
- It tracks up to MAX_OUT in-flight accesses in order, and returns load data that is already lane-extracted and sign/zero-extended.
- It cancels in-flight responses on pipeline flush (CSR reset, exception, ertn).

Parameters:
- DATA_W, 32, bus and register data width; legal values are 32 and 64.
- ADDR_W, 32, address width.
- MAX_OUT, 2, maximum outstanding accesses; power of 2, at least 1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  cancels the current issue and discards all outstanding responses
- ex_valid  in  1  EX holds a valid load/store
- ex_wr  in  1  1 = store, 0 = load
- ex_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword
- ex_signed  in  1  sign-extend load result
- ex_addr  in  ADDR_W  effective address
- ex_wdata  in  DATA_W  store source register value
- ex_block  in  1  older exception in MEM/WB; suppresses the access
- ex_ready  out  1  access done from EX's view; EX may advance
- ex_adem  out  1  misaligned/illegal-size exception (combinational)
- data_req  out  1  bus request
- data_wr  out  1  bus write
- data_size  out  2  equals ex_size
- data_addr  out  ADDR_W  ex_addr with the low log2(DATA_W/8) bits cleared
- data_wstrb  out  DATA_W/8  byte strobes; all zero for loads
- data_wdata  out  DATA_W  lane-replicated store data
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  response for the oldest outstanding access
- data_rdata  in  DATA_W  read data, full bus width
- resp_valid  out  1  one-cycle pulse for a completed, non-discarded access
- resp_wr  out  1  completed access was a store
- resp_rdata  out  DATA_W  extended load data; 0 for stores
- busy  out  1  outstanding count is non-zero

Behaviour:
- Size legality and ADEM:
  - size 3 is illegal when DATA_W = 32.
  - ex_adem = ex_valid & (illegal size | (ex_addr mod 2^size) != 0).
- Bus request:
  - data_req = ex_valid & ~ex_adem & ~ex_block & ~flush & (count < MAX_OUT).
  - Purely combinational. EX holds its inputs stable until ex_ready.
- Strobes:
  - off = ex_addr[log2(DATA_W/8)-1:0].
  - data_wstrb = ((1 << 2^size) - 1) << off when ex_wr, otherwise 0.
- Write data: ex_wdata low 2^size bytes replicated across all DATA_W/8 lanes.
- ex_ready:
  - Equals (data_req & data_addr_ok).
  - Also asserts for an access that is not issued: (ex_valid & (ex_adem | ex_block)).
  - Suppressed accesses create no FIFO entry and no resp_valid.
- Outstanding FIFO:
  - MAX_OUT entries, each {wr, size, signed, off, discard}.
  - Push on data_req & data_addr_ok. Pop on data_data_ok.
  - Pointers wrap modulo MAX_OUT. A 0..MAX_OUT counter drives full (count == MAX_OUT) and busy.
  - Push and pop in the same cycle leave count unchanged.
  - When full, data_req stays low until a pop occurs. A pop in the full cycle does not raise data_req until the next cycle.
  - data_data_ok never arrives in the same cycle as its own addr_ok; an entry pushed this cycle is not poppable this cycle.
  - data_data_ok while count == 0 is ignored, with no state change.
- Response path, registered with 1-cycle latency after data_data_ok of a non-discarded entry:
  - resp_valid = 1, resp_wr = entry.wr.
  - resp_rdata = data_rdata lane at byte entry.off, width 2^size bytes, sign- or zero-extended per entry.signed to DATA_W. Stores give 0.
  - resp_valid is low in every other cycle.
  - There is no backpressure: the consumer must accept every resp_valid cycle.
- Flush:
  - In the flush cycle, data_req = 0 and ex_ready does not assert for bus accesses.
  - Every live entry gets discard = 1.
  - Discarded entries still pop on data_data_ok, with no resp_valid.
  - An entry pushed in the cycle after flush is not discarded.
  - Flush coinciding with a pop: the popped entry is discarded.
  - busy stays high until all discarded entries drain.
- Reset:
  - Pointers and count are 0; all entries are invalid with discard = 0.
  - resp_valid = 0, resp_wr = 0, resp_rdata = 0, busy = 0.
  - Reset mid-transaction abandons outstanding entries. The bus owner is reset at the same time.

Test Plan:
- DATA_W = 32, store word 0x12345678 to 0x1000 with addr_ok in the same cycle:
  - Expect data_req = 1, wstrb = 4'b1111, data_addr = 0x1000, ex_ready = 1.
  - data_ok two cycles later gives resp_valid with resp_wr = 1.
- Store byte 0xAB to 0x1003:
  - Expect wstrb = 4'b1000, wdata = 0xABABABAB.
- Load half at 0x1001:
  - Expect ex_adem = 1, data_req = 0, ex_ready = 1, busy stays 0.
- Load byte signed at 0x2002 with rdata = 0x0080_0000:
  - Expect resp_rdata = 0xFFFFFF80.
  - Unsigned variant gives 0x00000080.
- MAX_OUT = 2, three back-to-back loads with addr_ok always high and data_ok held off:
  - Third data_req is low while count = 2.
  - After one data_ok, the third issues one cycle later; responses return in issue order.
- Two loads outstanding, assert flush for one cycle, then two data_ok:
  - Expect no resp_valid and busy falling to 0.
  - A subsequent load completes normally.
- DATA_W = 64, load dword at 0x3008:
  - Expect wstrb = 0 and resp_rdata = full rdata.
- DATA_W = 64, load word at 0x3004:
  - Expect resp_rdata = rdata[63:32] extended.

Source files
------------

// File: rtl/ex_mem_req_unit_if.sv
// rtl/ex_mem_req_unit_if.sv - data-memory request/response bus with addr_ok/data_ok handshakes
interface ex_mem_req_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  data_req;
  logic                  data_wr;
  logic [1:0]            data_size;
  logic [ADDR_W-1:0]     data_addr;
  logic [DATA_W/8-1:0]   data_wstrb;
  logic [DATA_W-1:0]     data_wdata;
  logic                  data_addr_ok;
  logic                  data_data_ok;
  logic [DATA_W-1:0]     data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/ex_mem_req_unit.sv
// rtl/ex_mem_req_unit.sv - EX-stage memory request unit: strobes, ADEM, in-order outstanding tracking, load extension
module ex_mem_req_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int MAX_OUT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic              ex_wr,
  input  logic [1:0]        ex_size,
  input  logic              ex_signed,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic              ex_block,
  output logic              ex_ready,
  output logic              ex_adem,
  ex_mem_req_unit_if.master bus,
  output logic              resp_valid,
  output logic              resp_wr,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              busy
);
  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CNT_W = $clog2(MAX_OUT + 1);

  logic [OFF_W-1:0] off;
  logic             illegal_size;
  logic             misaligned;
  logic             full;
  logic [7:0]       size_mask;
  logic [NB-1:0]    lane_mask;
  logic             push;
  logic             pop;
  logic             pop_live;

  logic             fifo_wr      [MAX_OUT];
  logic             fifo_signed  [MAX_OUT];
  logic             fifo_discard [MAX_OUT];
  logic [1:0]       fifo_size    [MAX_OUT];
  logic [OFF_W-1:0] fifo_off     [MAX_OUT];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] load_ext;
  logic              fill;
  int                nbits;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUT - 1)) ? '0 : p + 1'b1;
  endfunction

  assign off = ex_addr[OFF_W-1:0];

  always_comb begin
    illegal_size = (ex_size == 2'd3) && (DATA_W == 32);
    case (ex_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = ex_addr[0];
      2'd2:    misaligned = |ex_addr[1:0];
      default: misaligned = |ex_addr[2:0];
    endcase
    case (ex_size)
      2'd0:    size_mask = 8'h01;
      2'd1:    size_mask = 8'h03;
      2'd2:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  end

  assign lane_mask = size_mask[NB-1:0];
  assign ex_adem   = ex_valid & (illegal_size | misaligned);
  assign full      = (count == CNT_W'(MAX_OUT));
  assign busy      = (count != '0);

  // full is taken from the registered count, so a pop never frees a slot in its own cycle
  assign bus.data_req   = ex_valid & ~ex_adem & ~ex_block & ~flush & ~full;
  assign bus.data_wr    = ex_wr;
  assign bus.data_size  = ex_size;
  assign bus.data_addr  = {ex_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign bus.data_wstrb = ex_wr ? (lane_mask << off) : '0;

  always_comb begin
    bus.data_wdata = '0;
    for (int i = 0; i < NB; i++) begin
      bus.data_wdata[8*i +: 8] = ex_wdata[8*(i % (1 << ex_size)) +: 8];
    end
  end

  assign push     = bus.data_req & bus.data_addr_ok;
  assign pop      = bus.data_data_ok & busy;
  assign pop_live = pop & ~fifo_discard[rd_ptr] & ~flush;
  assign ex_ready = push | (ex_valid & (ex_adem | ex_block));

  always_comb begin
    shifted = bus.data_rdata >> {fifo_off[rd_ptr], 3'b000};
    nbits   = 8 << fifo_size[rd_ptr];
    if (nbits > DATA_W) nbits = DATA_W;
    fill     = fifo_signed[rd_ptr] & shifted[nbits-1];
    load_ext = shifted;
    for (int i = 0; i < DATA_W; i++) begin
      if (i >= nbits) load_ext[i] = fill;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      resp_valid <= 1'b0;
      resp_wr    <= 1'b0;
      resp_rdata <= '0;
      for (int i = 0; i < MAX_OUT; i++) begin
        fifo_wr[i]      <= 1'b0;
        fifo_signed[i]  <= 1'b0;
        fifo_discard[i] <= 1'b0;
        fifo_size[i]    <= 2'd0;
        fifo_off[i]     <= '0;
      end
    end else begin
      if (flush) begin
        for (int i = 0; i < MAX_OUT; i++) fifo_discard[i] <= 1'b1;
      end
      if (push) begin
        fifo_wr[wr_ptr]      <= ex_wr;
        fifo_signed[wr_ptr]  <= ex_signed;
        fifo_size[wr_ptr]    <= ex_size;
        fifo_off[wr_ptr]     <= off;
        fifo_discard[wr_ptr] <= 1'b0;
        wr_ptr               <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      count      <= count + CNT_W'(push) - CNT_W'(pop);
      resp_valid <= pop_live;
      if (pop_live) begin
        resp_wr    <= fifo_wr[rd_ptr];
        resp_rdata <= fifo_wr[rd_ptr] ? '0 : load_ext;
      end
    end
  end
endmodule
